// File: rtl/expr_eval_if.sv
// Character bus into the expression evaluator and its registered result/status.
interface expr_eval_if #(parameter int unsigned W = 16);
   logic [7:0]   in;
   logic [W-1:0] result;
   logic         valid;
   logic         err;
   logic         ovf;

   modport master (output in, input result, valid, err, ovf);
   modport slave  (input in, output result, valid, err, ovf);
endinterface

// File: rtl/expr_eval.sv
// Running evaluator for single-digit "+"/"*" ASCII expressions, '*' binds tighter.
module expr_eval #(
   parameter int unsigned W = 16
) (
   input logic         clk,
   input logic         clr,
   expr_eval_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, NUM, OP, ERR} state_t;

   state_t       state;
   logic [W-1:0] sum;
   logic [W-1:0] term;
   logic         mul_pend;

   logic           is_dig, is_add, is_mul, is_nul;
   logic [3:0]     d;
   logic [2*W-1:0] add_w;
   logic [2*W-1:0] mul_w;
   logic [W-1:0]   op_term;
   logic           op_ovf;

   always_comb begin
      is_dig  = (bus.in >= 8'h30) && (bus.in <= 8'h39);
      is_add  = (bus.in == 8'h2B);
      is_mul  = (bus.in == 8'h2A);
      is_nul  = (bus.in == 8'h00);
      d       = bus.in[3:0];
      add_w   = {{W{1'b0}}, sum} + {{W{1'b0}}, term};
      mul_w   = {{W{1'b0}}, term} * {{(2*W-4){1'b0}}, d};
      // Term after a digit in OP: either extends a product or starts a new one.
      op_term = '0;
      op_ovf  = 1'b0;
      if (mul_pend) begin
         op_term = mul_w[W-1:0];
         op_ovf  = |mul_w[2*W-1:W];
      end else begin
         op_term = {{(W-4){1'b0}}, d};
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= IDLE;
         sum        <= '0;
         term       <= '0;
         mul_pend   <= 1'b0;
         bus.result <= '0;
         bus.valid  <= 1'b0;
         bus.err    <= 1'b0;
         bus.ovf    <= 1'b0;
      end else if (!is_nul) begin
         case (state)
            IDLE: begin
               if (is_dig) begin
                  state      <= NUM;
                  sum        <= '0;
                  term       <= {{(W-4){1'b0}}, d};
                  mul_pend   <= 1'b0;
                  bus.result <= {{(W-4){1'b0}}, d};
                  bus.valid  <= 1'b1;
               end else begin
                  state     <= ERR;
                  bus.valid <= 1'b0;
                  bus.err   <= 1'b1;
               end
            end
            NUM: begin
               if (is_add) begin
                  state      <= OP;
                  sum        <= add_w[W-1:0];
                  term       <= '0;
                  mul_pend   <= 1'b0;
                  bus.result <= add_w[W-1:0];
                  bus.valid  <= 1'b0;
                  if (|add_w[2*W-1:W]) bus.ovf <= 1'b1;
               end else if (is_mul) begin
                  state      <= OP;
                  mul_pend   <= 1'b1;
                  bus.result <= add_w[W-1:0];
                  bus.valid  <= 1'b0;
               end else begin
                  state     <= ERR;
                  bus.valid <= 1'b0;
                  bus.err   <= 1'b1;
               end
            end
            OP: begin
               if (is_dig) begin
                  state      <= NUM;
                  term       <= op_term;
                  bus.result <= sum + op_term;
                  bus.valid  <= 1'b1;
                  if (op_ovf) bus.ovf <= 1'b1;
               end else begin
                  state     <= ERR;
                  bus.valid <= 1'b0;
                  bus.err   <= 1'b1;
               end
            end
            default: begin
               state     <= ERR;
               bus.valid <= 1'b0;
               bus.err   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench: a W=16 and a W=8 evaluator share one character stream.
module tb_expr_eval;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] drv = 8'h00;

   always #10 clk = ~clk;

   expr_eval_if #(.W(16)) b16 ();
   expr_eval_if #(.W(8))  b8 ();
   assign b16.in = drv;
   assign b8.in  = drv;

   expr_eval #(.W(16)) u16 (.clk(clk), .clr(clr), .bus(b16.slave));
   expr_eval #(.W(8))  u8  (.clk(clk), .clr(clr), .bus(b8.slave));

   typedef struct {
      logic [15:0] res;
      logic        v;
      logic        e;
      logic        o;
   } exp_t;

   exp_t q16[$];
   exp_t q8[$];

   int checks   = 0;
   int failures = 0;

   // Reference model state, index 0 = W16, index 1 = W8.
   int     m_st[2];
   longint m_sum[2], m_term[2], m_res[2];
   bit     m_mp[2], m_v[2], m_e[2], m_o[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int unsigned k = 0; k < 2; k++) begin
         m_st[k] = 0; m_sum[k] = 0; m_term[k] = 0; m_res[k] = 0;
         m_mp[k] = 0; m_v[k] = 0; m_e[k] = 0; m_o[k] = 0;
      end
   endtask

   task automatic model(input int k, input int w, input logic [7:0] c);
      longint mask = (longint'(1) << w) - 1;
      longint dd   = longint'(c) - 48;
      bit     dig  = (c >= 8'h30) && (c <= 8'h39);
      bit     bad  = 0;
      longint t;
      exp_t   x;
      if (c != 8'h00) begin
         case (m_st[k])
            0: if (dig) begin
                  m_st[k] = 1; m_sum[k] = 0; m_term[k] = dd; m_mp[k] = 0;
                  m_res[k] = dd; m_v[k] = 1;
               end else bad = 1;
            1: if (c == 8'h2B) begin
                  t = m_sum[k] + m_term[k];
                  if (t > mask) m_o[k] = 1;
                  m_sum[k] = t & mask; m_term[k] = 0; m_mp[k] = 0;
                  m_res[k] = m_sum[k]; m_v[k] = 0; m_st[k] = 2;
               end else if (c == 8'h2A) begin
                  m_mp[k] = 1; m_st[k] = 2; m_v[k] = 0;
                  m_res[k] = (m_sum[k] + m_term[k]) & mask;
               end else bad = 1;
            2: if (dig) begin
                  t = m_mp[k] ? m_term[k] * dd : dd;
                  if (t > mask) m_o[k] = 1;
                  m_term[k] = t & mask;
                  m_res[k] = (m_sum[k] + m_term[k]) & mask;
                  m_v[k] = 1; m_st[k] = 1;
               end else bad = 1;
            default: ;
         endcase
         if (bad) begin
            m_st[k] = 3; m_e[k] = 1; m_v[k] = 0;
         end
      end
      x.res = 16'(m_res[k]); x.v = m_v[k]; x.e = m_e[k]; x.o = m_o[k];
      if (k == 0) q16.push_back(x); else q8.push_back(x);
   endtask

   task automatic compare_outputs();
      exp_t x;
      if (q16.size() == 0) chk("q16_empty", 1, 0);
      else begin
         x = q16.pop_front();
         chk("w16_result", 32'(b16.result), 32'(x.res));
         chk("w16_valid",  32'(b16.valid),  32'(x.v));
         chk("w16_err",    32'(b16.err),    32'(x.e));
         chk("w16_ovf",    32'(b16.ovf),    32'(x.o));
      end
      if (q8.size() == 0) chk("q8_empty", 1, 0);
      else begin
         x = q8.pop_front();
         chk("w8_result", 32'(b8.result), 32'(x.res));
         chk("w8_valid",  32'(b8.valid),  32'(x.v));
         chk("w8_err",    32'(b8.err),    32'(x.e));
         chk("w8_ovf",    32'(b8.ovf),    32'(x.o));
      end
   endtask

   task automatic send(input logic [7:0] c);
      drv = c;
      model(0, 16, c);
      model(1, 8, c);
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic send_str(input string s);
      for (int unsigned i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic do_clear(input logic [7:0] c);
      drv = c;
      clr = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk("clr_result", 32'(b16.result), 0);
      chk("clr_valid",  32'(b16.valid),  0);
      chk("clr_err",    32'(b16.err),    0);
      chk("clr_ovf",    32'(b16.ovf),    0);
      chk("clr_result8", 32'(b8.result), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      @(posedge clk);
      #1;
      do_clear(8'h31);

      send_str("1+9+8");
      chk("sum18", 32'(b16.result), 18);
      chk("sum18_valid", 32'(b16.valid), 1);

      do_clear(8'h2A);
      send_str("2+3*4");
      chk("prec14", 32'(b16.result), 14);

      do_clear(8'h00);
      send_str("1+9");
      do_clear(8'h00);
      send_str("1*");
      chk("trail_op_result", 32'(b16.result), 1);
      chk("trail_op_valid",  32'(b16.valid), 0);
      chk("trail_op_err",    32'(b16.err), 0);

      do_clear(8'h35);
      send_str("1++3");
      chk("sticky_err", 32'(b16.err), 1);
      chk("frozen_res", 32'(b16.result), 1);

      do_clear(8'h39);
      send_str("9*9*9");
      chk("w8_wrap", 32'(b8.result), 217);
      chk("w8_ovf_set", 32'(b8.ovf), 1);
      chk("w16_729", 32'(b16.result), 729);
      chk("w16_no_ovf", 32'(b16.ovf), 0);

      do_clear(8'h00);
      send(8'h35); send(8'h00); send(8'h00); send(8'h2B); send(8'h00); send(8'h32);
      chk("nul_sum7", 32'(b16.result), 7);

      do_clear(8'h00);
      send_str("a");
      chk("bad_first", 32'(b16.err), 1);

      do_clear(8'h00);
      send_str("12");
      chk("multi_digit", 32'(b16.err), 1);

      // Longer mixed stream to drive both widths through several sums and products.
      do_clear(8'h00);
      send_str("9*9*9*9+8*7+9*9*9+5");
      do_clear(8'h00);
      for (int unsigned i = 0; i < 40; i++) begin
         if (i % 2 == 0) send(8'(8'h30 + $urandom_range(0, 9)));
         else send(($urandom_range(0, 2) == 0) ? 8'h2B : 8'h2A);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
